// File: rtl/ps2_key_tracker_pkg.sv
// Shared constants, rx state encoding and BCD helper for the PS/2 key tracker.
// Latency: none (package only). Backpressure: not applicable.
package ps2_pkg;

   localparam logic [7:0] KBD_BREAK  = 8'hF0;
   localparam logic [7:0] KBD_EXT    = 8'hE0;
   localparam int         FRAME_BITS = 11;

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_e;

   typedef struct packed {
      logic [3:0] hi;
      logic [3:0] lo;
   } bcd2_t;

   // Two-digit BCD increment; 99 wraps silently to 00.
   function automatic bcd2_t bcd2_inc(input bcd2_t v);
      bcd2_t r;
      r = v;
      if (v.lo == 4'd9) begin
         r.lo = 4'd0;
         r.hi = (v.hi == 4'd9) ? 4'd0 : v.hi + 4'd1;
      end else begin
         r.lo = v.lo + 4'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/ps2_key_tracker_if.sv
// Keyboard pins in, seven-segment digit nibbles and blank flags out.
// Latency: wiring only. Backpressure: none, display values are level signals.
interface ps2_key_tracker_if;
   logic       ps2_clk;
   logic       ps2_data;
   logic [3:0] code_lo;
   logic [3:0] code_hi;
   logic       code_show;
   logic [3:0] cnt_lo;
   logic [3:0] cnt_hi;
   logic       cnt_show;
   logic       frame_err;

   modport master (
      input  ps2_clk, ps2_data,
      output code_lo, code_hi, code_show, cnt_lo, cnt_hi, cnt_show, frame_err
   );

   modport slave (
      output ps2_clk, ps2_data,
      input  code_lo, code_hi, code_show, cnt_lo, cnt_hi, cnt_show, frame_err
   );
endinterface

// File: rtl/ps2_key_tracker_rx.sv
// PS/2 frame receiver: pin synchronisers, falling-edge detect, 11-bit frame FSM, inter-edge timeout.
// Latency: byte_vld/frame_err one cycle after the internal stop fall. Backpressure: none.
module ps2_rx
   import ps2_pkg::*;
#(
   parameter int TIMEOUT_CYC = 12500
) (
   input  logic       clk,
   input  logic       clrn,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] byte_dat,
   output logic       byte_vld,
   output logic       frame_err
);

   localparam int TW        = $clog2(TIMEOUT_CYC + 1);
   localparam int DATA_BITS = FRAME_BITS - 3;

   logic [2:0]  clk_sync_q, clk_sync_d;
   logic [2:0]  dat_sync_q, dat_sync_d;
   rx_state_e   state_q, state_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [7:0]  shift_q, shift_d;
   logic        par_q, par_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [7:0]  byte_q, byte_d;
   logic        vld_q, vld_d;
   logic        err_q, err_d;

   logic fall;
   logic din;

   assign fall = clk_sync_q[2] & ~clk_sync_q[1];
   assign din  = dat_sync_q[2];

   always_comb begin
      clk_sync_d = {clk_sync_q[1:0], ps2_clk};
      dat_sync_d = {dat_sync_q[1:0], ps2_data};
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      par_d      = par_q;
      byte_d     = byte_q;
      vld_d      = 1'b0;
      err_d      = 1'b0;

      if (state_q == IDLE || fall) tmo_d = '0;
      else                         tmo_d = tmo_q + 1'b1;

      case (state_q)
         IDLE: begin
            if (fall && !din) begin
               state_d   = DATA;
               bit_cnt_d = '0;
               par_d     = 1'b0;
            end
         end
         DATA: begin
            if (fall) begin
               shift_d   = {din, shift_q[7:1]};
               par_d     = par_q ^ din;
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'(DATA_BITS - 1)) state_d = PARITY;
            end
         end
         PARITY: begin
            if (fall) begin
               par_d   = par_q ^ din;
               state_d = STOP;
            end
         end
         STOP: begin
            if (fall) begin
               // par_q is 1 when data plus parity bit hold an odd number of ones.
               if (din && par_q) begin
                  vld_d  = 1'b1;
                  byte_d = shift_q;
               end else begin
                  err_d  = 1'b1;
               end
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (state_q != IDLE && !fall && tmo_q == TW'(TIMEOUT_CYC - 1)) begin
         state_d = IDLE;
         err_d   = 1'b1;
         tmo_d   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!clrn) begin
         clk_sync_q <= '1;
         dat_sync_q <= '1;
         state_q    <= IDLE;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         par_q      <= 1'b0;
         tmo_q      <= '0;
         byte_q     <= '0;
         vld_q      <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         clk_sync_q <= clk_sync_d;
         dat_sync_q <= dat_sync_d;
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         par_q      <= par_d;
         tmo_q      <= tmo_d;
         byte_q     <= byte_d;
         vld_q      <= vld_d;
         err_q      <= err_d;
      end
   end

   assign byte_dat  = byte_q;
   assign byte_vld  = vld_q;
   assign frame_err = err_q;

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 key tracker: make/break decode of the current key plus a two-digit BCD press counter.
// Latency: display updates two cycles after the internal stop fall. Backpressure: none.
module ps2_key_tracker
   import ps2_pkg::*;
#(
   parameter int TIMEOUT_CYC = 12500
) (
   input  logic                clk,
   input  logic                clrn,
   ps2_key_tracker_if.master   kbd
);

   logic [7:0] byte_dat;
   logic       byte_vld;
   logic       rx_err;

   ps2_rx #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
      .clk       (clk),
      .clrn      (clrn),
      .ps2_clk   (kbd.ps2_clk),
      .ps2_data  (kbd.ps2_data),
      .byte_dat  (byte_dat),
      .byte_vld  (byte_vld),
      .frame_err (rx_err)
   );

   logic [7:0] code_q, code_d;
   logic       code_show_q, code_show_d;
   logic       brk_q, brk_d;
   logic       ext_q, ext_d;
   logic       cnt_show_q, cnt_show_d;
   bcd2_t      cnt_q, cnt_d;

   always_comb begin
      code_d      = code_q;
      code_show_d = code_show_q;
      brk_d       = brk_q;
      ext_d       = ext_q;
      cnt_show_d  = cnt_show_q;
      cnt_d       = cnt_q;

      if (byte_vld) begin
         if (byte_dat == KBD_EXT) begin
            ext_d = 1'b1;
         end else if (byte_dat == KBD_BREAK) begin
            brk_d = 1'b1;
         end else if (brk_q) begin
            // Release only blanks the digits; the last code stays latched.
            if (code_show_q && byte_dat == code_q) code_show_d = 1'b0;
            brk_d = 1'b0;
            ext_d = 1'b0;
         end else if (!(code_show_q && byte_dat == code_q)) begin
            code_d      = byte_dat;
            code_show_d = 1'b1;
            cnt_d       = bcd2_inc(cnt_q);
            cnt_show_d  = 1'b1;
            ext_d       = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!clrn) begin
         code_q      <= '0;
         code_show_q <= 1'b0;
         brk_q       <= 1'b0;
         ext_q       <= 1'b0;
         cnt_show_q  <= 1'b0;
         cnt_q       <= '0;
      end else begin
         code_q      <= code_d;
         code_show_q <= code_show_d;
         brk_q       <= brk_d;
         ext_q       <= ext_d;
         cnt_show_q  <= cnt_show_d;
         cnt_q       <= cnt_d;
      end
   end

   assign kbd.code_lo   = code_q[3:0];
   assign kbd.code_hi   = code_q[7:4];
   assign kbd.code_show = code_show_q;
   assign kbd.cnt_lo    = cnt_q.lo;
   assign kbd.cnt_hi    = cnt_q.hi;
   assign kbd.cnt_show  = cnt_show_q;
   assign kbd.frame_err = rx_err;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Bench for ps2_key_tracker: table vectors, hand-written corner sequences, random frames vs a key model.
module tb_ps2_key_tracker;

   localparam int T = 100;   // shortened frame-abort timeout
   localparam int H = 8;     // ps2_clk half period in system cycles

   logic clk = 1'b0;
   logic clrn = 1'b0;
   always #5 clk = ~clk;

   ps2_key_tracker_if kbd ();

   ps2_key_tracker #(.TIMEOUT_CYC(T)) dut (
      .clk  (clk),
      .clrn (clrn),
      .kbd  (kbd)
   );

   int checks = 0;
   int errors = 0;

   int cyc = 0;
   int err_total = 0;
   int err_wide = 0;
   int last_err_cyc = 0;
   logic prev_err = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      prev_err <= kbd.frame_err;
      if (kbd.frame_err) begin
         err_total    <= err_total + 1;
         last_err_cyc <= cyc;
         if (prev_err) err_wide <= err_wide + 1;
      end
   end

   initial begin
      repeat (90000) @(posedge clk);
      $display("FAIL watchdog cycles=%0d required=<90000", cyc);
      $fatal(1, "watchdog");
   end

   // Behavioural key model: held code, pending break, decimal press count.
   int m_code, m_count;
   bit m_show, m_brk, m_cshow;

   task automatic model_reset();
      m_code = 0; m_count = 0; m_show = 0; m_brk = 0; m_cshow = 0;
   endtask

   task automatic model_byte(input int b);
      if (b == 'hE0) begin
      end else if (b == 'hF0) begin
         m_brk = 1;
      end else if (m_brk) begin
         if (m_show && b == m_code) m_show = 0;
         m_brk = 0;
      end else if (!(m_show && b == m_code)) begin
         m_code  = b;
         m_show  = 1;
         m_count = (m_count + 1) % 100;
         m_cshow = 1;
      end
   endtask

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic check_model(input string tag);
      check({tag, ".code_lo"},   kbd.code_lo,   m_code % 16);
      check({tag, ".code_hi"},   kbd.code_hi,   m_code / 16);
      check({tag, ".code_show"}, kbd.code_show, m_show);
      check({tag, ".cnt_lo"},    kbd.cnt_lo,    m_count % 10);
      check({tag, ".cnt_hi"},    kbd.cnt_hi,    m_count / 10);
      check({tag, ".cnt_show"},  kbd.cnt_show,  m_cshow);
   endtask

   // Drives the first nbits frame bits; returns on the negedge where the last bit's fall is driven.
   task automatic send_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int nbits);
      logic [10:0] f;
      f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         repeat (H / 2) @(negedge clk);
         kbd.ps2_data = f[i];
         repeat (H / 2) @(negedge clk);
         kbd.ps2_clk = 1'b0;
         if (i != nbits - 1) begin
            repeat (H) @(negedge clk);
            kbd.ps2_clk = 1'b1;
         end
      end
   endtask

   task automatic finish_frame();
      repeat (H) @(negedge clk);
      kbd.ps2_clk  = 1'b1;
      kbd.ps2_data = 1'b1;
      repeat (3 * H) @(negedge clk);
   endtask

   task automatic run_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, output int n_err);
      int e0;
      e0 = err_total;
      send_bits(b, bad_par, bad_stop, 11);
      finish_frame();
      n_err = err_total - e0;
      if (!bad_par && !bad_stop) model_byte(int'(b));
   endtask

   typedef struct {
      logic [7:0] b;
      bit         bad_par;
      bit         bad_stop;
      logic [7:0] exp_code;
      bit         exp_show;
      int         exp_cnt;
      int         exp_err;
   } vec_t;

   vec_t vecs[$];

   initial begin
      int n_err, e0, t0, guard;
      logic [7:0] rb;
      bit bad, bp;

      vecs = '{
         '{8'h1C, 0, 0, 8'h1C, 1, 1, 0},
         '{8'h1C, 0, 0, 8'h1C, 1, 1, 0},
         '{8'h1C, 0, 0, 8'h1C, 1, 1, 0},
         '{8'hF0, 0, 0, 8'h1C, 1, 1, 0},
         '{8'h1C, 0, 0, 8'h1C, 0, 1, 0},
         '{8'h1C, 1, 0, 8'h1C, 0, 1, 1},
         '{8'h1C, 0, 1, 8'h1C, 0, 1, 1},
         '{8'h2A, 0, 0, 8'h2A, 1, 2, 0},
         '{8'hE0, 0, 0, 8'h2A, 1, 2, 0},
         '{8'h32, 0, 0, 8'h32, 1, 3, 0},
         '{8'hF0, 0, 0, 8'h32, 1, 3, 0},
         '{8'h2A, 0, 0, 8'h32, 1, 3, 0},
         '{8'h32, 0, 0, 8'h32, 1, 3, 0},
         '{8'h32, 1, 0, 8'h32, 1, 3, 1}
      };

      kbd.ps2_clk  = 1'b1;
      kbd.ps2_data = 1'b1;
      model_reset();
      repeat (3) @(negedge clk);
      check_model("reset");
      check("reset.frame_err", kbd.frame_err, 0);
      clrn = 1'b1;
      repeat (4) @(negedge clk);

      // First key: exact two-cycle tracker latency after the internal stop fall.
      e0 = err_total;
      send_bits(8'h1C, 0, 0, 11);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("lat.pre_show", kbd.code_show, 0);
      check("lat.pre_cnt",  kbd.cnt_lo, 0);
      @(posedge clk);
      @(negedge clk);
      model_byte('h1C);
      check_model("lat.post");
      finish_frame();
      check("lat.frame_err", err_total - e0, 0);

      foreach (vecs[i]) begin
         run_frame(vecs[i].b, vecs[i].bad_par, vecs[i].bad_stop, n_err);
         check($sformatf("vec%0d.code", i), {kbd.code_hi, kbd.code_lo}, vecs[i].exp_code);
         check($sformatf("vec%0d.show", i), kbd.code_show, vecs[i].exp_show);
         check($sformatf("vec%0d.cnt", i), kbd.cnt_hi * 10 + kbd.cnt_lo, vecs[i].exp_cnt);
         check($sformatf("vec%0d.err", i), n_err, vecs[i].exp_err);
      end
      check_model("vec_end");

      // Abort after 4 data bits: the timeout fires about TIMEOUT_CYC after the last fall.
      e0 = err_total;
      send_bits(8'h2A, 0, 0, 5);
      t0 = cyc;
      repeat (H) @(negedge clk);
      kbd.ps2_clk  = 1'b1;
      kbd.ps2_data = 1'b1;
      for (int k = 0; k < T + 50 && err_total == e0; k++) @(negedge clk);
      repeat (3) @(negedge clk);
      check("tmo.pulses", err_total - e0, 1);
      check("tmo.in_window", int'((last_err_cyc - t0) >= T && (last_err_cyc - t0) <= T + 4), 1);
      check_model("tmo.hold");
      run_frame(8'h2A, 0, 0, n_err);
      check("tmo.next_err", n_err, 0);
      check_model("tmo.next");

      // Reset pulse while the receiver waits for the parity fall.
      e0 = err_total;
      send_bits(8'h1C, 0, 0, 9);
      repeat (H) @(negedge clk);
      kbd.ps2_clk = 1'b1;
      repeat (H / 2) @(negedge clk);
      clrn = 1'b0;
      @(negedge clk);
      clrn = 1'b1;
      model_reset();
      check_model("midrst");
      check("midrst.frame_err", kbd.frame_err, 0);
      kbd.ps2_data = 1'b1;
      repeat (T + 20) @(negedge clk);
      check("midrst.no_err", err_total - e0, 0);
      check_model("midrst.idle");
      run_frame(8'h15, 0, 0, n_err);
      check_model("midrst.next");

      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 9))
            0, 1:    rb = 8'hF0;
            2:       rb = 8'hE0;
            3, 4:    rb = 8'h1C;
            5:       rb = 8'h32;
            default: rb = 8'($urandom_range(0, 255));
         endcase
         bad = ($urandom_range(0, 9) == 0);
         bp  = bad && ($urandom_range(0, 1) == 1);
         run_frame(rb, bp, bad && !bp, n_err);
         check($sformatf("rnd%0d.err", i), n_err, int'(bad));
         check_model($sformatf("rnd%0d", i));
      end

      // Count up to 98 with alternating fresh keys, then 1C, F0 1C, 32 crosses 99 -> 00.
      guard = 0;
      while (!(m_count == 98 && !m_brk && m_show && (m_code == 'h21 || m_code == 'h22)) && guard < 250) begin
         run_frame((m_show && m_code == 'h21) ? 8'h22 : 8'h21, 0, 0, n_err);
         guard++;
      end
      check("wrap.guard_ok", int'(guard < 250), 1);
      check_model("wrap.98");
      run_frame(8'h1C, 0, 0, n_err);
      check("wrap.99", kbd.cnt_hi * 10 + kbd.cnt_lo, 99);
      run_frame(8'hF0, 0, 0, n_err);
      run_frame(8'h1C, 0, 0, n_err);
      check("wrap.released", kbd.code_show, 0);
      run_frame(8'h32, 0, 0, n_err);
      check("wrap.cnt_lo", kbd.cnt_lo, 0);
      check("wrap.cnt_hi", kbd.cnt_hi, 0);
      check("wrap.cnt_show", kbd.cnt_show, 1);
      check("wrap.code", {kbd.code_hi, kbd.code_lo}, 'h32);
      check("wrap.code_show", kbd.code_show, 1);

      check("frame_err.one_cycle_wide", err_wide, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
